// File: rtl/id_stage_pipe_pkg.sv
// Shared constants for the ToruMIPS decode stage: opcodes, function codes,
// ALU operation/selection encodings and reset/NOP conventions.
package id_stage_pipe_pkg;

  localparam logic RST_ENABLE = 1'b1;

  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LW      = 6'b100011;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  // ALU operations
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [ALUOP_W-1:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP    = 8'b1110_0011;

  // ALU result selection
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP        = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITHMETIC = 3'b100;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOAD_STORE = 3'b111;

  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_ZERO,
    IMM_SIGN,
    IMM_LUI
  } imm_kind_e;

endpackage

// File: rtl/id_stage_pipe_decode.sv
// Combinational instruction decoder: read enables, destination, immediate,
// ALU op/sel, load flag and invalid-instruction flag.
module id_decode
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic [31:0]         inst,
  output logic                reg1_read,
  output logic                reg2_read,
  output logic                shift,
  output logic [RADDR_W-1:0]  wd,
  output logic                wreg,
  output logic [DATA_W-1:0]   imm,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [ALUSEL_W-1:0] alusel,
  output logic                is_load,
  output logic                invalid
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  imm_kind_e  imm_kind;

  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];

  always_comb begin
    reg1_read = 1'b0;
    reg2_read = 1'b0;
    shift     = 1'b0;
    wd        = RADDR_W'(rt);
    wreg      = 1'b0;
    imm_kind  = IMM_NONE;
    aluop     = EXE_NOP_OP;
    alusel    = EXE_RES_NOP;
    is_load   = 1'b0;
    invalid   = 1'b0;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        reg1_read = 1'b1;
        wreg      = 1'b1;
        imm_kind  = IMM_ZERO;
        alusel    = EXE_RES_LOGIC;
        aluop     = (op == OP_ORI)  ? EXE_OR_OP  :
                    (op == OP_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
      end
      OP_LUI: begin
        reg1_read = 1'b1;
        wreg      = 1'b1;
        imm_kind  = IMM_LUI;
        aluop     = EXE_OR_OP;
        alusel    = EXE_RES_LOGIC;
      end
      OP_ADDIU: begin
        reg1_read = 1'b1;
        wreg      = 1'b1;
        imm_kind  = IMM_SIGN;
        aluop     = EXE_ADDIU_OP;
        alusel    = EXE_RES_ARITHMETIC;
      end
      OP_LW: begin
        reg1_read = 1'b1;
        wreg      = 1'b1;
        imm_kind  = IMM_SIGN;
        aluop     = EXE_LW_OP;
        alusel    = EXE_RES_LOAD_STORE;
        is_load   = 1'b1;
      end
      OP_SPECIAL: begin
        wd = RADDR_W'(rd);
        case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            reg1_read = 1'b1;
            reg2_read = 1'b1;
            wreg      = 1'b1;
            alusel    = EXE_RES_LOGIC;
            aluop     = (funct == FN_AND) ? EXE_AND_OP :
                        (funct == FN_OR)  ? EXE_OR_OP  :
                        (funct == FN_XOR) ? EXE_XOR_OP : EXE_NOR_OP;
          end
          FN_ADDU, FN_SUBU: begin
            reg1_read = 1'b1;
            reg2_read = 1'b1;
            wreg      = 1'b1;
            alusel    = EXE_RES_ARITHMETIC;
            aluop     = (funct == FN_ADDU) ? EXE_ADDU_OP : EXE_SUBU_OP;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            reg2_read = 1'b1;
            shift     = 1'b1;
            wreg      = 1'b1;
            alusel    = EXE_RES_SHIFT;
            aluop     = (funct == FN_SLL) ? EXE_SLL_OP :
                        (funct == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
          end
          default: invalid = 1'b1;
        endcase
      end
      default: invalid = 1'b1;
    endcase
    // $0 is hard-wired, so a write to it is dropped here rather than in WB
    if (wd == '0) wreg = 1'b0;
  end

  always_comb begin
    case (imm_kind)
      IMM_ZERO: imm = DATA_W'(inst[15:0]);
      IMM_SIGN: imm = DATA_W'($signed(inst[15:0]));
      IMM_LUI:  imm = DATA_W'({inst[15:0], 16'h0000});
      default:  imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered ToruMIPS decode stage: operand forwarding from EX/MEM, load-use
// stall detection and the ID/EX pipeline register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         pc_i,
  input  logic [31:0]         inst_i,
  output logic                reg1_read_o,
  output logic [RADDR_W-1:0]  reg1_addr_o,
  input  logic [DATA_W-1:0]   reg1_data_i,
  output logic                reg2_read_o,
  output logic [RADDR_W-1:0]  reg2_addr_o,
  input  logic [DATA_W-1:0]   reg2_data_i,
  input  logic                ex_wreg_i,
  input  logic [RADDR_W-1:0]  ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [RADDR_W-1:0]  mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         pc_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [RADDR_W-1:0]  wd_o,
  output logic                wreg_o,
  output logic                is_load_o,
  output logic                inst_invalid_o
);

  logic                shift;
  logic [RADDR_W-1:0]  dec_wd;
  logic                dec_wreg;
  logic [DATA_W-1:0]   dec_imm;
  logic [ALUOP_W-1:0]  dec_aluop;
  logic [ALUSEL_W-1:0] dec_alusel;
  logic                dec_is_load;
  logic                dec_invalid;

  id_decode #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_decode (
    .inst      (inst_i),
    .reg1_read (reg1_read_o),
    .reg2_read (reg2_read_o),
    .shift     (shift),
    .wd        (dec_wd),
    .wreg      (dec_wreg),
    .imm       (dec_imm),
    .aluop     (dec_aluop),
    .alusel    (dec_alusel),
    .is_load   (dec_is_load),
    .invalid   (dec_invalid)
  );

  assign reg1_addr_o = RADDR_W'(inst_i[25:21]);
  assign reg2_addr_o = RADDR_W'(inst_i[20:16]);

  logic r1_ex_hit, r2_ex_hit, r1_mem_hit, r2_mem_hit;
  logic stall, advance;

  assign r1_ex_hit  = reg1_read_o && (reg1_addr_o != '0) && ex_wreg_i  && (ex_wd_i  == reg1_addr_o);
  assign r2_ex_hit  = reg2_read_o && (reg2_addr_o != '0) && ex_wreg_i  && (ex_wd_i  == reg2_addr_o);
  assign r1_mem_hit = reg1_read_o && (reg1_addr_o != '0) && mem_wreg_i && (mem_wd_i == reg1_addr_o);
  assign r2_mem_hit = reg2_read_o && (reg2_addr_o != '0) && mem_wreg_i && (mem_wd_i == reg2_addr_o);

  // Without forwarding every in-flight RAW must wait until the value reaches the regfile
  always_comb begin
    if (FWD_EN) stall = (r1_ex_hit || r2_ex_hit) && ex_is_load_i;
    else        stall = r1_ex_hit || r2_ex_hit || r1_mem_hit || r2_mem_hit;
  end

  // Handshake: a beat transfers on a side whenever valid and ready are both
  // high at the rising edge. in_ready_o never depends on in_valid_i, and the
  // ID/EX entry is held unchanged while out_valid_o && !out_ready_i.
  assign advance    = !out_valid_o || out_ready_i;
  assign in_ready_o = advance && !stall && !flush_i;

  logic [DATA_W-1:0] fwd1, fwd2, op1, op2;

  always_comb begin
    fwd1 = reg1_data_i;
    if (reg1_addr_o == '0)                  fwd1 = '0;
    else if (FWD_EN && r1_ex_hit && !ex_is_load_i) fwd1 = ex_wdata_i;
    else if (FWD_EN && r1_mem_hit)          fwd1 = mem_wdata_i;

    fwd2 = reg2_data_i;
    if (reg2_addr_o == '0)                  fwd2 = '0;
    else if (FWD_EN && r2_ex_hit && !ex_is_load_i) fwd2 = ex_wdata_i;
    else if (FWD_EN && r2_mem_hit)          fwd2 = mem_wdata_i;

    if (shift)            op1 = DATA_W'(inst_i[10:6]);
    else if (reg1_read_o) op1 = fwd1;
    else                  op1 = dec_imm;

    op2 = reg2_read_o ? fwd2 : dec_imm;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      out_valid_o    <= 1'b0;
      pc_o           <= '0;
      aluop_o        <= EXE_NOP_OP;
      alusel_o       <= EXE_RES_NOP;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= RADDR_W'(NOP_REG_ADDR);
      wreg_o         <= 1'b0;
      is_load_o      <= 1'b0;
      inst_invalid_o <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      out_valid_o    <= 1'b1;
      pc_o           <= pc_i;
      aluop_o        <= dec_aluop;
      alusel_o       <= dec_alusel;
      reg1_o         <= op1;
      reg2_o         <= op2;
      wd_o           <= dec_wd;
      wreg_o         <= dec_wreg;
      is_load_o      <= dec_is_load;
      inst_invalid_o <= dec_invalid;
    end else if (advance) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, forwarding, load-use stall,
// back-pressure, flush, invalid opcodes, $0 writes and reset while holding.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush_i, out_valid_o, out_ready_i;
  logic [31:0] pc_o, reg1_o, reg2_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [4:0]  wd_o;
  logic        wreg_o, is_load_o, inst_invalid_o;

  int tests = 0;
  int fails = 0;

  id_stage_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .pc_i           (pc_i),
    .inst_i         (inst_i),
    .reg1_read_o    (reg1_read_o),
    .reg1_addr_o    (reg1_addr_o),
    .reg1_data_i    (reg1_data_i),
    .reg2_read_o    (reg2_read_o),
    .reg2_addr_o    (reg2_addr_o),
    .reg2_data_i    (reg2_data_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .ex_wdata_i     (ex_wdata_i),
    .ex_is_load_i   (ex_is_load_i),
    .mem_wreg_i     (mem_wreg_i),
    .mem_wd_i       (mem_wd_i),
    .mem_wdata_i    (mem_wdata_i),
    .flush_i        (flush_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .pc_o           (pc_o),
    .aluop_o        (aluop_o),
    .alusel_o       (alusel_o),
    .reg1_o         (reg1_o),
    .reg2_o         (reg2_o),
    .wd_o           (wd_o),
    .wreg_o         (wreg_o),
    .is_load_o      (is_load_o),
    .inst_invalid_o (inst_invalid_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid_i = 1'b0; pc_i = '0; inst_i = '0;
    reg1_data_i = '0; reg2_data_i = '0;
    ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
    flush_i = 1'b0; out_ready_i = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_aluop", 32'(aluop_o), 32'h00);
    chk("rst_alusel", 32'(alusel_o), 32'd0);
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_reg1", reg1_o, 32'd0);
    rst = 1'b0;

    // 1. ori $1,$0,0x8001 ; regfile data must be ignored for $0
    in_valid_i = 1'b1; pc_i = 32'h100; inst_i = 32'h3401_8001;
    reg1_data_i = 32'h1111_1111; reg2_data_i = 32'h2222_2222;
    #1 chk("ori_ready", 32'(in_ready_o), 32'd1);
    chk("ori_raddr1", 32'(reg1_addr_o), 32'd0);
    tick();
    chk("ori_valid", 32'(out_valid_o), 32'd1);
    chk("ori_reg1", reg1_o, 32'h0);
    chk("ori_reg2", reg2_o, 32'h0000_8001);
    chk("ori_wd", 32'(wd_o), 32'd1);
    chk("ori_wreg", 32'(wreg_o), 32'd1);
    chk("ori_aluop", 32'(aluop_o), 32'h25);
    chk("ori_pc", pc_o, 32'h100);

    // 2. addiu $2,$1,0xFFFF with EX forwarding of $1 = 5
    pc_i = 32'h104; inst_i = 32'h2422_FFFF;
    ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'd5;
    tick();
    chk("addiu_reg1", reg1_o, 32'd5);
    chk("addiu_reg2", reg2_o, 32'hFFFF_FFFF);
    chk("addiu_wd", 32'(wd_o), 32'd2);
    chk("addiu_alusel", 32'(alusel_o), 32'd4);

    // 3. lw $3 in EX, addu $4,$3,$3 in ID -> stall, bubble, then MEM forward
    pc_i = 32'h108; inst_i = 32'h0063_2021;
    ex_wd_i = 5'd3; ex_is_load_i = 1'b1; ex_wdata_i = 32'h5555_5555;
    #1 chk("lu_ready", 32'(in_ready_o), 32'd0);
    tick();
    chk("lu_bubble", 32'(out_valid_o), 32'd0);
    ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd3; mem_wdata_i = 32'hDEAD_BEEF;
    #1 chk("lu_ready2", 32'(in_ready_o), 32'd1);
    tick();
    chk("lu_valid", 32'(out_valid_o), 32'd1);
    chk("lu_reg1", reg1_o, 32'hDEAD_BEEF);
    chk("lu_reg2", reg2_o, 32'hDEAD_BEEF);
    chk("lu_wd", 32'(wd_o), 32'd4);
    chk("lu_aluop", 32'(aluop_o), 32'h21);

    // 4. back-pressure for 3 cycles, then release
    mem_wreg_i = 1'b0;
    out_ready_i = 1'b0; pc_i = 32'h10C; inst_i = 32'h3407_1234;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(in_ready_o), 32'd0);
      tick();
      chk("bp_valid", 32'(out_valid_o), 32'd1);
      chk("bp_reg1", reg1_o, 32'hDEAD_BEEF);
      chk("bp_wd", 32'(wd_o), 32'd4);
    end
    out_ready_i = 1'b1;
    #1 chk("bp_rel_ready", 32'(in_ready_o), 32'd1);
    tick();
    chk("bp_rel_wd", 32'(wd_o), 32'd7);
    chk("bp_rel_reg2", reg2_o, 32'h0000_1234);

    // 5. flush with a full register and a valid input
    pc_i = 32'h110; inst_i = 32'h3409_0009; flush_i = 1'b1;
    #1 chk("fl_ready", 32'(in_ready_o), 32'd0);
    tick();
    chk("fl_valid", 32'(out_valid_o), 32'd0);
    flush_i = 1'b0;
    tick();
    chk("fl_retry_valid", 32'(out_valid_o), 32'd1);
    chk("fl_retry_wd", 32'(wd_o), 32'd9);

    // 6. invalid opcode, then sll $5,$6,4
    pc_i = 32'h114; inst_i = 32'hFC00_0000;
    tick();
    chk("inv_valid", 32'(out_valid_o), 32'd1);
    chk("inv_flag", 32'(inst_invalid_o), 32'd1);
    chk("inv_wreg", 32'(wreg_o), 32'd0);
    chk("inv_aluop", 32'(aluop_o), 32'h00);
    pc_i = 32'h118; inst_i = 32'h0006_2900; reg2_data_i = 32'h0000_000F;
    tick();
    chk("sll_reg1", reg1_o, 32'd4);
    chk("sll_reg2", reg2_o, 32'h0000_000F);
    chk("sll_wd", 32'(wd_o), 32'd5);
    chk("sll_aluop", 32'(aluop_o), 32'h7C);
    chk("sll_alusel", 32'(alusel_o), 32'd2);
    chk("sll_inv", 32'(inst_invalid_o), 32'd0);

    // 7. ori $0,$1,5 -> write to $0 suppressed
    pc_i = 32'h11C; inst_i = 32'h3420_0005; reg1_data_i = 32'h1111_1111;
    tick();
    chk("z_wreg", 32'(wreg_o), 32'd0);
    chk("z_reg1", reg1_o, 32'h1111_1111);
    chk("z_reg2", reg2_o, 32'd5);

    // 8. lw then reset while the entry is held
    pc_i = 32'h120; inst_i = 32'h8C2A_0004;
    tick();
    chk("lw_isload", 32'(is_load_o), 32'd1);
    chk("lw_alusel", 32'(alusel_o), 32'd7);
    out_ready_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid_i = 1'b0;
    tick();
    chk("rh_valid", 32'(out_valid_o), 32'd0);
    chk("rh_isload", 32'(is_load_o), 32'd0);
    chk("rh_wd", 32'(wd_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
